// File: rtl/servo_pkg.sv
// Shared defaults and angle helpers for the four-channel servo PWM generator.
// The clamp and ramp functions are shared by every channel instance.
package servo_pkg;
  localparam int ANG_W              = 8;
  localparam int CW                 = 15;
  localparam int PRESC_DEF          = 50;
  localparam int PERIODO_DEF        = 20000;
  localparam int ANCHO_MIN_DEF      = 1000;
  localparam int PASO_DEF           = 5;
  localparam int ANGULO_MAX_DEF     = 180;
  localparam int RAMPA_DEF          = 10;
  localparam int ANGULO_INICIAL_DEF = 90;

  function automatic logic [ANG_W-1:0] limitar(input logic [ANG_W-1:0] a,
                                                input logic [ANG_W-1:0] maxv);
    return (a > maxv) ? maxv : a;
  endfunction

  // Step toward the target by at most paso_max; the difference is 9-bit signed.
  function automatic logic [ANG_W-1:0] rampa(input logic [ANG_W-1:0] actual,
                                              input logic [ANG_W-1:0] objetivo,
                                              input logic [ANG_W-1:0] paso_max);
    logic signed [ANG_W:0] dif;
    logic signed [ANG_W:0] lim;
    dif = $signed({1'b0, objetivo}) - $signed({1'b0, actual});
    lim = $signed({1'b0, paso_max});
    if (dif > lim)       return actual + paso_max;
    else if (dif < -lim) return actual - paso_max;
    else                 return objetivo;
  endfunction
endpackage

// File: rtl/canal_servo.sv
// One servo channel: clamp, per-period ramp, width register and the pulse
// comparator against the shared period counter.
module canal_servo
  import servo_pkg::*;
#(
  parameter int ANCHO_MIN      = ANCHO_MIN_DEF,
  parameter int PASO           = PASO_DEF,
  parameter int ANGULO_MAX     = ANGULO_MAX_DEF,
  parameter int RAMPA          = RAMPA_DEF,
  parameter int ANGULO_INICIAL = ANGULO_INICIAL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frontera,
  input  logic             habilitar,
  input  logic             hab_reg,
  input  logic [ANG_W-1:0] angulo_cmd,
  input  logic [CW-1:0]    cont_periodo,
  output logic             pwm,
  output logic [ANG_W-1:0] actual
);
  logic [ANG_W-1:0] objetivo, siguiente;
  logic [15:0]      ancho, ancho_sig;

  assign objetivo  = limitar(angulo_cmd, ANG_W'(ANGULO_MAX));
  assign siguiente = habilitar ? rampa(actual, objetivo, ANG_W'(RAMPA)) : actual;
  assign ancho_sig = 16'(ANCHO_MIN) + 16'(siguiente) * 16'(PASO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      actual <= ANG_W'(ANGULO_INICIAL);
      ancho  <= 16'(ANCHO_MIN + ANGULO_INICIAL * PASO);
      pwm    <= 1'b0;
    end else begin
      if (frontera) begin
        actual <= siguiente;
        ancho  <= ancho_sig;
      end
      pwm <= hab_reg && (16'(cont_periodo) < ancho);
    end
  end
endmodule

// File: rtl/generador_pwm_servos.sv
// Four-channel hobby-servo PWM generator: shared prescaler and period counter,
// enable latched at period boundaries, one canal_servo per joint.
module generador_pwm_servos
  import servo_pkg::*;
#(
  parameter int PRESC          = PRESC_DEF,
  parameter int PERIODO        = PERIODO_DEF,
  parameter int ANCHO_MIN      = ANCHO_MIN_DEF,
  parameter int PASO           = PASO_DEF,
  parameter int ANGULO_MAX     = ANGULO_MAX_DEF,
  parameter int RAMPA          = RAMPA_DEF,
  parameter int ANGULO_INICIAL = ANGULO_INICIAL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             habilitar,
  input  logic [ANG_W-1:0] angulo_servo_1,
  input  logic [ANG_W-1:0] angulo_servo_2,
  input  logic [ANG_W-1:0] angulo_servo_3,
  input  logic [ANG_W-1:0] angulo_servo_4,
  output logic [3:0]       pwm_servo,
  output logic             inicio_periodo,
  output logic [31:0]      angulo_actual
);
  localparam int NUM_CANALES = 4;
  localparam int PW          = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [PW-1:0] cont_presc;
  logic [CW-1:0] cont_periodo;
  logic          tick, frontera, hab_reg;
  logic [NUM_CANALES-1:0][ANG_W-1:0] angulos, actuales;

  assign angulos        = {angulo_servo_4, angulo_servo_3, angulo_servo_2, angulo_servo_1};
  assign angulo_actual  = actuales;
  assign tick           = (cont_presc == PW'(PRESC - 1));
  assign frontera       = tick && (cont_periodo == CW'(PERIODO - 1));
  assign inicio_periodo = frontera;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_presc   <= '0;
      cont_periodo <= '0;
      hab_reg      <= 1'b0;
    end else begin
      cont_presc <= tick ? '0 : cont_presc + 1'b1;
      if (frontera)  cont_periodo <= '0;
      else if (tick) cont_periodo <= cont_periodo + 1'b1;
      if (frontera)  hab_reg <= habilitar;
    end
  end

  for (genvar i = 0; i < NUM_CANALES; i++) begin : g_canal
    canal_servo #(
      .ANCHO_MIN(ANCHO_MIN), .PASO(PASO), .ANGULO_MAX(ANGULO_MAX),
      .RAMPA(RAMPA), .ANGULO_INICIAL(ANGULO_INICIAL)
    ) u_canal (
      .clk          (clk),
      .rst_n        (rst_n),
      .frontera     (frontera),
      .habilitar    (habilitar),
      .hab_reg      (hab_reg),
      .angulo_cmd   (angulos[i]),
      .cont_periodo (cont_periodo),
      .pwm          (pwm_servo[i]),
      .actual       (actuales[i])
    );
  end
endmodule

// File: tb/tb_generador_pwm_servos.sv
// Directed bench for generador_pwm_servos with shortened timing: 2 clk per
// tick, 300 ticks per period, width = 100 + angle ticks.
module tb_generador_pwm_servos;
  localparam int PRESC   = 2;
  localparam int PERIODO = 300;
  localparam int CLK_PER = PRESC * PERIODO;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       habilitar = 1'b0;
  logic [7:0] a1 = 8'd90, a2 = 8'd90, a3 = 8'd90, a4 = 8'd90;
  logic [3:0] pwm_servo;
  logic       inicio_periodo;
  logic [31:0] angulo_actual;

  int errores = 0;
  int checks  = 0;
  int cnt[4];

  generador_pwm_servos #(
    .PRESC(PRESC), .PERIODO(PERIODO), .ANCHO_MIN(100), .PASO(1),
    .ANGULO_MAX(180), .RAMPA(10), .ANGULO_INICIAL(90)
  ) dut (
    .clk(clk), .rst_n(rst_n), .habilitar(habilitar),
    .angulo_servo_1(a1), .angulo_servo_2(a2),
    .angulo_servo_3(a3), .angulo_servo_4(a4),
    .pwm_servo(pwm_servo), .inicio_periodo(inicio_periodo),
    .angulo_actual(angulo_actual)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errores++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one full period starting at the clk where inicio_periodo is high,
  // counting high clk per pin, and ends at the next such clk.
  task automatic medir(input int hab_off_at, input bit glitch);
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int k = 0; k < CLK_PER; k++) begin
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++) if (pwm_servo[c]) cnt[c]++;
      if (k == hab_off_at) habilitar = 1'b0;
      if (glitch && k == 100) a2 = 8'd0;
      if (glitch && k == 300) a2 = 8'd90;
    end
    chk("periodo_fin", 32'(inicio_periodo), 32'd1);
  endtask

  // Counts clk from reset release to the first boundary; pins must stay low.
  task automatic primer_periodo(input string tag);
    int  k;
    bit  alto;
    k = 0; alto = 0;
    while (k < 2000) begin
      @(posedge clk); #1;
      k++;
      if (pwm_servo != 4'h0) alto = 1;
      if (inicio_periodo) break;
    end
    chk({tag, "_primera_frontera"}, 32'(k), 32'(CLK_PER - 1));
    chk({tag, "_silencio"}, 32'(alto), 32'd0);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_pwm", 32'(pwm_servo), 32'h0);
    chk("rst_inicio", 32'(inicio_periodo), 32'h0);
    chk("rst_actual", angulo_actual, 32'h5A5A5A5A);

    habilitar = 1'b1;
    rst_n = 1'b1;
    primer_periodo("arranque");

    medir(-1, 0);
    for (int c = 0; c < 4; c++) chk($sformatf("p2_ch%0d", c + 1), 32'(cnt[c]), 32'd380);
    chk("p2_actual", angulo_actual, 32'h5A5A5A5A);

    // Ramp channels 1 and 3 from 90 to 180 in 10-degree steps.
    a1 = 8'd180; a3 = 8'd180;
    for (int p = 1; p <= 9; p++) begin
      medir(-1, 0);
      chk($sformatf("rampa_p%0d_ch1", p), 32'(cnt[0]), 32'(2 * (190 + 10 * p)));
      chk($sformatf("rampa_p%0d_ang1", p), 32'(angulo_actual[7:0]), 32'(90 + 10 * p));
    end
    medir(-1, 0);
    chk("estable_ch1", 32'(cnt[0]), 32'd560);
    chk("estable_ch3", 32'(cnt[2]), 32'd560);

    // Over-range command and a sub-ramp step on channel 4.
    a3 = 8'd255; a4 = 8'd95;
    medir(-1, 0);
    chk("sat_ch3", 32'(cnt[2]), 32'd560);
    chk("sat_ang3", 32'(angulo_actual[23:16]), 32'd180);
    chk("paso_ch4", 32'(cnt[3]), 32'd390);
    chk("ch2_fijo", 32'(cnt[1]), 32'd380);

    // Enable dropped mid-pulse: this pulse completes, next period is low.
    a1 = 8'd100;
    medir(100, 0);
    chk("hab_off_ch1", 32'(cnt[0]), 32'd540);
    chk("hab_off_ch3", 32'(cnt[2]), 32'd560);
    medir(-1, 0);
    chk("apagado_ch1", 32'(cnt[0]), 32'd0);
    chk("apagado_ch3", 32'(cnt[2]), 32'd0);
    chk("congelado", angulo_actual, 32'h5FB45AAA);
    habilitar = 1'b1;
    medir(-1, 0);
    chk("reanuda_ch1", 32'(cnt[0]), 32'd520);
    chk("reanuda_ang1", 32'(angulo_actual[7:0]), 32'd160);

    // Transient command on channel 2 inside one period.
    medir(-1, 1);
    chk("glitch_ch1", 32'(cnt[0]), 32'd500);
    medir(-1, 0);
    chk("glitch_ch2", 32'(cnt[1]), 32'd380);
    chk("glitch_ang2", 32'(angulo_actual[15:8]), 32'd90);
    chk("glitch_ch1b", 32'(cnt[0]), 32'd480);

    // Reset in the middle of the pulse.
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_pwm", 32'(pwm_servo), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pwm", 32'(pwm_servo), 32'h0);
    chk("rst_mid_actual", angulo_actual, 32'h5A5A5A5A);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    primer_periodo("post_rst");
    medir(-1, 0);
    chk("post_rst_ch1", 32'(cnt[0]), 32'd400);
    chk("post_rst_ch2", 32'(cnt[1]), 32'd380);
    chk("post_rst_ch3", 32'(cnt[2]), 32'd400);
    chk("post_rst_ch4", 32'(cnt[3]), 32'd390);
    chk("post_rst_actual", angulo_actual, 32'h5F645A64);

    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end
endmodule

// File: doc/generador_pwm_servos.md
# generador_pwm_servos

Four-channel hobby-servo PWM generator that sits directly downstream of the serial angle receiver. It consumes the four 8-bit angle registers, angulo_servo_1..4, and drives one PWM pin per servo joint of the arm. Commands are latched only at period boundaries, clamped to 0..180°, and rate-limited per channel so a new command never causes a mechanical jump.

## Interface
Parameters:
- PRESC, 50: clk cycles per 1 µs tick (50 MHz clk).
- PERIODO, 20000: ticks per PWM period (20 ms).
- ANCHO_MIN, 1000: pulse width in ticks at 0°.
- PASO, 5: ticks per degree (180° → 1900 ticks).
- ANGULO_MAX, 180: clamp ceiling for commanded angles.
- RAMPA, 10: maximum change in degrees per period, per channel.
- ANGULO_INICIAL, 90: reset value of each channel's current angle.

Ports:
- clk, input, 1: single system clock.
- rst_n, input, 1: asynchronous active-low reset.
- habilitar, input, 1: PWM output enable, sampled at period boundary.
- angulo_servo_1..4, input, 8 each: commanded angles from the receiver, any value 0..255.
- pwm_servo, output, 4: registered PWM outputs; bit i drives servo i+1.
- inicio_periodo, output, 1: one-clk strobe on the last clk of each period.
- angulo_actual, output, 32: packed current angles {ch4,ch3,ch2,ch1}, 8 bits each.

## Operation
- Prescaler cont_presc counts 0..PRESC-1. tick is high when cont_presc==PRESC-1.
- Period counter cont_periodo (15 bits) advances on tick, counting 0..PERIODO-1 and wrapping to 0.
- Boundary event: tick && cont_periodo==PERIODO-1. inicio_periodo is high for exactly that clk. On that edge:
  - habilitar is latched into hab_reg.
  - Each channel forms objetivo = min(angulo_servo_i, ANGULO_MAX).
  - Each channel updates actual_i toward objetivo by at most RAMPA:
    - if |objetivo−actual| ≤ RAMPA, actual := objetivo;
    - otherwise actual moves RAMPA toward objetivo.
  - The update happens only when habilitar is high at that edge. Otherwise actual_i holds.
  - ancho_i = ANCHO_MIN + actual_i*PASO (16 bits, no overflow at defaults) is registered.
- Output rule: pwm_servo[i] = hab_reg && (cont_periodo < ancho_i), registered.
- Angle inputs and habilitar changes between boundaries have no effect until the next boundary. The receiver's update timing is therefore irrelevant.
- Width rules:
  - Subtraction and comparison for the ramp are done in 9-bit signed arithmetic.
  - actual_i never exceeds ANGULO_MAX.

## Timing
- Reset (asynchronous, immediate):
  - pwm_servo = 0, inicio_periodo = 0, hab_reg = 0;
  - cont_presc = 0, cont_periodo = 0;
  - actual_i = ANGULO_INICIAL, ancho_i = ANCHO_MIN + ANGULO_INICIAL*PASO.
- The first period after reset is silent (hab_reg=0). The first boundary occurs PRESC*PERIODO clk after rst_n release.
- Reset mid-pulse forces pwm low at once. Counting restarts from 0 on release.
- Latency: a command change reaches the pin at the start of the next period, one period at most plus ramp periods.
- Pulse rises on the clk after the boundary edge and lasts ancho_i*PRESC clk.
- habilitar 1→0 mid-period: the current pulse completes. The next period is fully low.
- Angle ≥ ANGULO_MAX, e.g. 200 or 255, is treated as ANGULO_MAX.
- Equal objetivo and actual leaves actual unchanged, with no dither.

## Structure
- Package servo_pkg holds the parameter defaults and the angle width (8). The ramp and clamp functions also live there.
- The natural sub-module is canal_servo, instantiated 4×. Each instance holds:
  - clamp, ramp register and ancho register;
  - its comparator against the shared cont_periodo.
- The top level owns the prescaler, the period counter, hab_reg and inicio_periodo.

## Test plan
- Reset released, habilitar=1, all angles 90: period 1 has pwm=0000. From period 2, each pin is high for 1450 ticks = 72 500 clk every 1 000 000 clk.
- Channel 1 at 90, command 180: widths over successive periods are 1500, 1550 … 1900 ticks (angles 100..180, 9 periods), then steady.
- Command 255 on channel 3 from steady 180: width stays 1900 ticks and angulo_actual[23:16]=180.
- habilitar dropped at mid-pulse: that pulse ends at its full width. The following period is all-low and actual angles freeze. Re-enable resumes ramping from the frozen value.
- rst_n asserted mid-pulse: pwm_servo=0 in the same cycle and angulo_actual=0x5A5A5A5A. The first boundary falls PRESC*PERIODO clk after release.
- Angle change between boundaries, command 0 then back to 90 within one period: no effect on width, and actual stays 90.
